// File: rtl/ntt_iter_if.sv
// Streaming handshake bundle for the ntt_iter engine: coefficient input,
// result output and status. The engine takes the slave modport.
interface ntt_iter_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;
    logic         done;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, done
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/ntt_iter.sv
// Iterative radix-2 NTT over Z_Q: bit-reversed load, one butterfly per cycle,
// natural-order unload. Define NTT_ITER_INTT_EN to add the inverse transform (inv port).
module ntt_iter #(
    parameter int N         = 8,
    parameter int W         = 8,
    parameter int Q         = 17,
`ifdef NTT_ITER_INTT_EN
    parameter int OMEGA_INV = 9,
    parameter int N_INV     = 15,
`endif
    parameter int OMEGA     = 2
) (
    input  logic      clk,
    input  logic      rst,
`ifdef NTT_ITER_INTT_EN
    input  logic      inv,
`endif
    ntt_iter_if.slave bus
);
    localparam int LOGN = $clog2(N);
    localparam int TWB  = (LOGN > 1) ? LOGN - 1 : 1;
    localparam int TWN  = 1 << TWB;
    localparam logic [W-1:0]   QW  = W'(Q);
    localparam logic [W:0]     QW1 = (W+1)'(Q);
    localparam logic [2*W-1:0] Q2  = (2*W)'(Q);

    generate
        if (N < 2 || (N & (N - 1)) != 0) begin : g_err_n
            $error("ntt_iter: N must be a power of two >= 2");
        end
        if (Q >= (1 << W)) begin : g_err_q
            $error("ntt_iter: Q must be smaller than 2^W");
        end
    endgenerate

    function automatic logic [W-1:0] pow_mod(input int base, input int e);
        longint r;
        r = 1;
        for (int i = 0; i < e; i++) r = (r * longint'(base)) % longint'(Q);
        return W'(r);
    endfunction

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] x);
        logic [LOGN-1:0] y;
        for (int i = 0; i < LOGN; i++) y[i] = x[LOGN-1-i];
        return y;
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

    state_t          r_state, w_state_next;
    logic [W-1:0]    r_mem [N];
    logic [LOGN-1:0] r_cnt;
    logic [LOGN-1:0] r_bfly;
    logic [4:0]      r_stage;
    logic [LOGN-1:0] r_k;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [W-1:0]    r_out_data;
    logic            r_inv;

    logic            w_in_fire, w_out_fire, w_last_in, w_last_bfly, w_last_out;
    logic [LOGN-1:0] w_mask, w_j, w_lo, w_hi, w_rd_addr;
    logic [TWB-1:0]  w_tw_idx;
    logic [W-1:0]    w_t, w_u, w_v, w_tv, w_sum_r, w_dif_r, w_rd, w_out_val;
    logic [2*W-1:0]  w_prod;
    logic [W:0]      w_sum, w_dif;
    logic [W-1:0]    w_tw_fwd [TWN];
    logic [W-1:0]    w_tw_inv [TWN];

    // Twiddle tables are pure constants: OMEGA^i mod Q for i < N/2
    genvar gi;
    generate
        for (gi = 0; gi < TWN; gi++) begin : g_tw
            localparam logic [W-1:0] TW_F = pow_mod(OMEGA, gi);
`ifdef NTT_ITER_INTT_EN
            localparam logic [W-1:0] TW_I = pow_mod(OMEGA_INV, gi);
`else
            localparam logic [W-1:0] TW_I = TW_F;
`endif
            assign w_tw_fwd[gi] = TW_F;
            assign w_tw_inv[gi] = TW_I;
        end
    endgenerate

    assign w_in_fire   = bus.in_valid & r_in_ready;
    assign w_out_fire  = r_out_valid & bus.out_ready;
    assign w_last_in   = (r_cnt == LOGN'(N - 1));
    assign w_last_bfly = (r_bfly == LOGN'(N / 2 - 1)) && (r_stage == 5'(LOGN - 1));
    assign w_last_out  = w_out_fire && (r_k == LOGN'(N - 1));

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = w_last_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_in_fire) w_state_next = S_LOAD;
            S_LOAD:    if (w_in_fire && w_last_in) w_state_next = S_COMPUTE;
            S_COMPUTE: if (w_last_bfly) w_state_next = S_UNLOAD;
            S_UNLOAD:  if (w_last_out) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Butterfly b of stage s: group base = (b >> s) << (s+1), offset j = b mod 2^s
    always_comb begin
        w_mask   = (LOGN'(1) << r_stage) - LOGN'(1);
        w_j      = r_bfly & w_mask;
        w_lo     = ((r_bfly >> r_stage) << (r_stage + 5'd1)) | w_j;
        w_hi     = w_lo | (LOGN'(1) << r_stage);
        w_tw_idx = TWB'(w_j << (5'(LOGN - 1) - r_stage));
        w_t      = r_inv ? w_tw_inv[w_tw_idx] : w_tw_fwd[w_tw_idx];
        w_u      = r_mem[w_lo];
        w_v      = r_mem[w_hi];
        w_prod   = {{W{1'b0}}, w_t} * {{W{1'b0}}, w_v};
        w_tv     = W'(w_prod % Q2);
        w_sum    = {1'b0, w_u} + {1'b0, w_tv};
        w_dif    = {1'b0, w_u} + QW1 - {1'b0, w_tv};
        w_sum_r  = (w_sum >= QW1) ? W'(w_sum - QW1) : W'(w_sum);
        w_dif_r  = (w_dif >= QW1) ? W'(w_dif - QW1) : W'(w_dif);
    end

    // First UNLOAD cycle fetches M[0]; each transfer then prefetches M[k+1]
    assign w_rd_addr = r_out_valid ? (r_k + LOGN'(1)) : '0;
    assign w_rd      = r_mem[w_rd_addr];

`ifdef NTT_ITER_INTT_EN
    localparam logic [2*W-1:0] NINV_W = (2*W)'(N_INV);
    logic [2*W-1:0] w_scaled;
    assign w_scaled  = ({{W{1'b0}}, w_rd} * NINV_W) % Q2;
    assign w_out_val = r_inv ? W'(w_scaled) : w_rd;
`else
    assign w_out_val = w_rd;
`endif

    always_ff @(posedge clk) begin
        if (w_in_fire) r_mem[bitrev(r_cnt)] <= W'(bus.in_data % QW);
        if (r_state == S_COMPUTE) begin
            r_mem[w_lo] <= w_sum_r;
            r_mem[w_hi] <= w_dif_r;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_bfly      <= '0;
            r_stage     <= '0;
            r_k         <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_inv       <= 1'b0;
        end else begin
            r_in_ready <= (w_state_next == S_IDLE) || (w_state_next == S_LOAD);
            if (w_in_fire) r_cnt <= w_last_in ? '0 : r_cnt + LOGN'(1);
`ifdef NTT_ITER_INTT_EN
            if (w_in_fire && r_state == S_IDLE) r_inv <= inv;
`endif
            if (r_state == S_COMPUTE) begin
                if (r_bfly == LOGN'(N / 2 - 1)) begin
                    r_bfly  <= '0;
                    r_stage <= (r_stage == 5'(LOGN - 1)) ? 5'd0 : r_stage + 5'd1;
                end else begin
                    r_bfly <= r_bfly + LOGN'(1);
                end
            end
            if (r_state == S_UNLOAD) begin
                if (!r_out_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_out_val;
                    r_k         <= '0;
                end else if (w_out_fire) begin
                    if (r_k == LOGN'(N - 1)) begin
                        r_out_valid <= 1'b0;
                        r_k         <= '0;
                    end else begin
                        r_k        <= r_k + LOGN'(1);
                        r_out_data <= w_out_val;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ntt_iter.sv
// Scoreboard bench for ntt_iter: direct-DFT reference model feeds an expected
// queue; an independent monitor pops and compares every output transfer.
module tb_ntt_iter;
    localparam int N     = 8;
    localparam int W     = 8;
    localparam int Q     = 17;
    localparam int OMEGA = 2;
    localparam int LAT   = (N / 2) * $clog2(N) + 1;
`ifdef NTT_ITER_INTT_EN
    localparam int OMEGA_INV = 9;
    localparam int N_INV     = 15;
`endif

    typedef struct {
        int data;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inv = 1'b0;

    ntt_iter_if #(.W(W)) bus ();

    ntt_iter #(.N(N), .W(W), .Q(Q), .OMEGA(OMEGA)) dut (
        .clk (clk),
        .rst (rst),
`ifdef NTT_ITER_INTT_EN
        .inv (inv),
`endif
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t_last = 0;
    int   done_cnt = 0;
    int   ready_mode = 0;
    int   stall_req = 0;
    int   stall_served = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int powm(input int b, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % Q;
        return r;
    endfunction

    // X[k] = sum a[n] * w^(n*k) mod Q, optionally scaled by N^-1 for the inverse
    function automatic void model(input int a[N], input bit iv, output int x[N]);
        int w = OMEGA;
        int s;
`ifdef NTT_ITER_INTT_EN
        if (iv) w = OMEGA_INV;
`endif
        for (int k = 0; k < N; k++) begin
            s = 0;
            for (int n = 0; n < N; n++) s = (s + (a[n] % Q) * powm(w, (n * k) % N)) % Q;
`ifdef NTT_ITER_INTT_EN
            if (iv) s = (s * N_INV) % Q;
`endif
            x[k] = s;
        end
    endfunction

    task automatic push_vec(input int x[N]);
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.data = x[k];
            e.last = (k == N - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_model(input int a[N], input bit iv);
        int x[N];
        model(a, iv, x);
        push_vec(x);
    endtask

    task automatic send_vec(input int a[N], input bit gaps, input bit iv);
        int g;
        for (int n = 0; n < N; n++) begin
            bus.in_valid = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = W'(a[n]);
            inv = (n == 0) ? iv : !iv;
            g = 0;
            @(negedge clk);
            while (!bus.in_ready && g < 200) begin
                g++;
                @(negedge clk);
            end
            if (!bus.in_ready) check("in_ready_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        t_last = cyc;
    endtask

    task automatic wait_done(input string name);
        int g = 0;
        while ((exp_q.size() != 0 || bus.busy) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check({name, "_complete"}, int'(exp_q.size() == 0 && !bus.busy), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string name, input int a[N], input bit gaps, input bit iv);
        int d0 = done_cnt;
        push_model(a, iv);
        send_vec(a, gaps, iv);
        wait_done(name);
        check({name, "_done_count"}, done_cnt - d0, 1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_out_valid"}, int'(bus.out_valid), 0);
        check({name, "_busy"}, int'(bus.busy), 0);
        check({name, "_done"}, int'(bus.done), 0);
        check({name, "_in_ready"}, int'(bus.in_ready), 0);
    endtask

    // Monitor: compares each transfer, done alignment, latency and stall stability
    initial begin : monitor
        exp_t e;
        bit   prev_valid = 1'b0;
        bit   prev_stall = 1'b0;
        int   held = 0;
        int   k;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (bus.done) done_cnt++;
                if (bus.out_valid && !prev_valid) check("latency", cyc - t_last, LAT);
                if (prev_stall && bus.out_valid) check("stall_hold", int'(bus.out_data), held);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        k = N - 1 - exp_q.size();
                        $display("t=%0t out k=%0d data=%0d expected=%0d done=%0d",
                                 $time, k, bus.out_data, e.data, bus.done);
                        check("out_data", int'(bus.out_data), e.data);
                        check("done_on_last", int'(bus.done), int'(e.last));
                    end
                end else if (bus.done) begin
                    check("spurious_done", 1, 0);
                end
                prev_valid = bus.out_valid;
                prev_stall = bus.out_valid && !bus.out_ready;
                held       = int'(bus.out_data);
            end
        end
    end

    // Downstream ready: always, random, or a 5-cycle hold-off when k=3 is presented
    initial begin : ready_drv
        int hold = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold > 0) begin
                hold--;
                bus.out_ready = 1'b0;
            end else if (ready_mode == 2 && stall_served < stall_req &&
                         bus.out_valid && exp_q.size() == N - 3) begin
                stall_served++;
                hold = 4;
                bus.out_ready = 1'b0;
            end else if (ready_mode == 1) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    initial begin : main
        int v[N];
        int x[N];
        int d0;
        int g;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_out_data", int'(bus.out_data), 0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        v = '{1, 0, 0, 0, 0, 0, 0, 0};
        run_one("impulse", v, 0, 0);
        v = '{0, 1, 0, 0, 0, 0, 0, 0};
        run_one("shifted_impulse", v, 0, 0);
        v = '{1, 1, 1, 1, 1, 1, 1, 1};
        run_one("all_ones", v, 0, 0);
        v = '{17, 18, 0, 0, 0, 0, 0, 0};
        run_one("over_q", v, 0, 0);

        ready_mode = 2;
        stall_req++;
        v = '{0, 1, 0, 0, 0, 0, 0, 0};
        run_one("gaps_stall_k3", v, 1, 0);
        check("stall_applied", stall_served, stall_req);

        ready_mode = 1;
        for (int t = 0; t < 4; t++) begin
            for (int n = 0; n < N; n++) v[n] = int'($urandom_range(0, 255));
            run_one("random", v, 1, 0);
        end

        d0 = done_cnt;
        for (int t = 0; t < 2; t++) begin
            for (int n = 0; n < N; n++) v[n] = int'($urandom_range(0, 255));
            push_model(v, 0);
            send_vec(v, 0, 0);
        end
        wait_done("back_to_back");
        check("back_to_back_done_count", done_cnt - d0, 2);
        ready_mode = 0;

        d0 = done_cnt;
        for (int n = 0; n < N; n++) v[n] = int'($urandom_range(0, 255));
        send_vec(v, 0, 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_reset_outputs("rst_compute");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1 check("rst_compute_no_done", done_cnt - d0, 0);

        d0 = done_cnt;
        push_model(v, 0);
        send_vec(v, 0, 0);
        g = 0;
        do begin
            @(negedge clk);
            #1;
            g++;
        end while (!(bus.out_valid && exp_q.size() == N - 5) && g < 100);
        check("rst_unload_reached_k4", int'(bus.out_valid && exp_q.size() == N - 5), 1);
        #1 rst = 1'b1;
        #1 check_reset_outputs("rst_unload");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("rst_unload_no_done", done_cnt - d0, 0);

        v = '{1, 0, 0, 0, 0, 0, 0, 0};
        run_one("impulse_after_reset", v, 0, 0);

`ifdef NTT_ITER_INTT_EN
        v = '{1, 2, 4, 8, 16, 15, 13, 9};
        run_one("inverse_shift", v, 0, 1);
        v = '{8, 0, 0, 0, 0, 0, 0, 0};
        run_one("inverse_dc", v, 0, 1);
        for (int t = 0; t < 3; t++) begin
            d0 = done_cnt;
            for (int n = 0; n < N; n++) v[n] = int'($urandom_range(0, 255));
            model(v, 0, x);
            push_vec(x);
            for (int n = 0; n < N; n++) v[n] = v[n] % Q;
            push_vec(v);
            send_vec(v, 0, 0);
            send_vec(x, 0, 1);
            wait_done("round_trip");
            check("round_trip_done_count", done_cnt - d0, 2);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
